// File: rtl/data_mem_responder.sv
// CPU data-memory slave: on-chip word RAM plus LED, button and cycle-counter registers.
// All reads return through a one-cycle registered path with read-before-write semantics.
module data_mem_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
  parameter int          N_BTN     = 11,
  parameter int          N_LED     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      address_i,
  input  logic [31:0]      data_i,
  input  logic             wren_i,
  input  logic             rden_i,
  input  logic [N_BTN-1:0] buttons_i,
  output logic [31:0]      data_o,
  output logic [N_LED-1:0] LEDs_o
);

  localparam int          RAM_WORDS = 2 ** RAM_AW;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_MMIO
  } rdSel_e;

  logic [31:0]       mem [RAM_WORDS];
  logic [31:0]       ramRd_q;
  logic [31:0]       mmioRd_q, mmioRd_d;
  rdSel_e            rdSel_q, rdSel_d;

  logic [N_LED-1:0]  led_q, led_d;
  logic [N_BTN-1:0]  s1_q, s2_q, s3_q;
  logic [N_BTN-1:0]  latch_q, latch_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              isRam, hitLed, hitNow, hitLatch, hitCyc;
  logic [RAM_AW-1:0] ramIdx;
  logic [N_BTN-1:0]  rise, clrMask;

  always_comb begin
    isRam    = address_i < RAM_LIMIT;
    hitLed   = address_i == MMIO_BASE;
    hitNow   = address_i == MMIO_BASE + 32'd1;
    hitLatch = address_i == MMIO_BASE + 32'd2;
    hitCyc   = address_i == MMIO_BASE + 32'd3;
    ramIdx   = address_i[RAM_AW-1:0];
  end

  // Read mux works on pre-edge register values, which is what gives read-before-write.
  always_comb begin
    mmioRd_d = '0;
    rdSel_d  = SEL_ZERO;
    if (isRam) begin
      rdSel_d = SEL_RAM;
    end else if (hitLed) begin
      rdSel_d              = SEL_MMIO;
      mmioRd_d[N_LED-1:0]  = led_q;
    end else if (hitNow) begin
      rdSel_d              = SEL_MMIO;
      mmioRd_d[N_BTN-1:0]  = s2_q;
    end else if (hitLatch) begin
      rdSel_d              = SEL_MMIO;
      mmioRd_d[N_BTN-1:0]  = latch_q;
    end else if (hitCyc) begin
      rdSel_d              = SEL_MMIO;
      mmioRd_d             = cycles_q;
    end
  end

  always_comb begin
    rise     = s2_q & ~s3_q;
    clrMask  = {N_BTN{rden_i && hitLatch}};
    latch_d  = (latch_q & ~clrMask) | rise;
    led_d    = (wren_i && hitLed) ? data_i[N_LED-1:0] : led_q;
    cycles_d = (wren_i && hitCyc) ? 32'd0 : cycles_q + 32'd1;
  end

  // RAM has no reset; writes are simply suppressed while RST is high.
  always_ff @(posedge CLK) begin
    if (!RST && wren_i && isRam) begin
      mem[ramIdx] <= data_i;
    end
    ramRd_q <= mem[ramIdx];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdSel_q  <= SEL_ZERO;
      mmioRd_q <= '0;
      led_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      latch_q  <= '0;
      cycles_q <= '0;
    end else begin
      rdSel_q  <= rdSel_d;
      mmioRd_q <= mmioRd_d;
      led_q    <= led_d;
      s1_q     <= buttons_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      latch_q  <= latch_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    data_o = '0;
    unique case (rdSel_q)
      SEL_RAM:  data_o = ramRd_q;
      SEL_MMIO: data_o = mmioRd_q;
      default:  data_o = '0;
    endcase
  end

  assign LEDs_o = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a per-edge behavioural model compared every cycle,
// plus directed sequences with literal expected values.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] IDLE  = 32'h2000_0000;
  localparam int          WORDS = 4096;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [10:0] btn = '0;
  logic [31:0] dataOut;
  logic [7:0]  leds;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 CLK = ~CLK;

  data_mem_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .address_i (addr),
    .data_i    (wdata),
    .wren_i    (we),
    .rden_i    (re),
    .buttons_i (btn),
    .data_o    (dataOut),
    .LEDs_o    (leds)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state: memory contents, register values and the last three button samples.
  logic [31:0] mRam [WORDS];
  bit          mValid [WORDS];
  logic [7:0]  mLed;
  logic [10:0] mLatch;
  logic [31:0] mCycles;
  logic [10:0] hist [3];
  logic [31:0] expData;
  bit          expKnown;
  bit          modelLive = 1'b0;

  always @(posedge CLK) begin
    logic [31:0] rd;
    logic [10:0] rise;
    bit          known;
    if (RST) begin
      expData   = '0;
      expKnown  = 1'b1;
      mLed      = '0;
      mLatch    = '0;
      mCycles   = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      rd    = '0;
      known = 1'b1;
      rise  = hist[1] & ~hist[2];
      if (addr < WORDS) begin
        rd    = mRam[addr[11:0]];
        known = mValid[addr[11:0]];
      end else if (addr == BASE)      rd = {24'h0, mLed};
      else if (addr == BASE + 32'd1)  rd = {21'h0, hist[1]};
      else if (addr == BASE + 32'd2)  rd = {21'h0, mLatch};
      else if (addr == BASE + 32'd3)  rd = mCycles;
      expData  = rd;
      expKnown = known;
      if (we && addr < WORDS) begin
        mRam[addr[11:0]]   = wdata;
        mValid[addr[11:0]] = 1'b1;
      end
      if (we && addr == BASE) mLed = wdata[7:0];
      if (we && addr == BASE + 32'd3) mCycles = '0;
      else mCycles = mCycles + 32'd1;
      if (re && addr == BASE + 32'd2) mLatch = rise;
      else mLatch = mLatch | rise;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = btn;
    end
    #1;
    if (modelLive) begin
      checkOutput("model LEDs_o", {24'h0, leds}, {24'h0, mLed});
      if (expKnown) checkOutput("model data_o", dataOut, expData);
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic rd, input logic [10:0] b);
    @(negedge CLK);
    RST   = r;
    addr  = a;
    wdata = d;
    we    = w;
    re    = rd;
    btn   = b;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    applyStimulus(1, IDLE, 0, 0, 0, 0);
    applyStimulus(1, IDLE, 0, 0, 0, 0);
    checkOutput("reset data_o", dataOut, 32'h0);
    checkOutput("reset LEDs_o", {24'h0, leds}, 32'h0);

    applyStimulus(0, 32'd5, 32'hDEAD_BEEF, 1, 0, 0);
    applyStimulus(0, 32'd5, 32'h0, 0, 1, 0);
    checkOutput("ram5 read", dataOut, 32'hDEAD_BEEF);

    applyStimulus(0, 32'd7, 32'h9, 1, 0, 0);
    applyStimulus(0, 32'd7, 32'h1, 1, 1, 0);
    checkOutput("ram7 read-before-write", dataOut, 32'h9);
    applyStimulus(0, 32'd7, 32'h0, 0, 1, 0);
    checkOutput("ram7 new data", dataOut, 32'h1);

    applyStimulus(0, BASE, 32'h1A5, 1, 0, 0);
    checkOutput("led pins", {24'h0, leds}, 32'hA5);
    applyStimulus(0, BASE, 32'h0, 0, 1, 0);
    checkOutput("led readback", dataOut, 32'h0000_00A5);

    for (int i = 0; i < 3; i++) applyStimulus(0, IDLE, 0, 0, 0, 11'h008);
    applyStimulus(0, BASE + 32'd1, 0, 0, 0, 11'h008);
    checkOutput("btn_now held", dataOut, 32'h8);
    applyStimulus(0, IDLE, 0, 0, 0, 11'h000);
    applyStimulus(0, IDLE, 0, 0, 0, 11'h000);
    applyStimulus(0, BASE + 32'd2, 0, 0, 1, 11'h000);
    checkOutput("latch sticky", dataOut, 32'h8);
    applyStimulus(0, BASE + 32'd2, 0, 0, 1, 11'h000);
    checkOutput("latch cleared", dataOut, 32'h0);

    applyStimulus(0, IDLE, 0, 0, 0, 11'h001);
    applyStimulus(0, IDLE, 0, 0, 0, 11'h001);
    applyStimulus(0, BASE + 32'd2, 0, 0, 1, 11'h001);
    checkOutput("latch clear cycle old", dataOut, 32'h0);
    applyStimulus(0, BASE + 32'd2, 0, 0, 1, 11'h001);
    checkOutput("latch rise survives", dataOut, 32'h1);
    applyStimulus(0, BASE + 32'd2, 0, 0, 1, 11'h000);
    checkOutput("latch after clear", dataOut, 32'h0);

    applyStimulus(0, BASE + 32'd3, 32'h1234_5678, 1, 0, 0);
    applyStimulus(0, IDLE, 0, 0, 0, 0);
    applyStimulus(0, IDLE, 0, 0, 0, 0);
    applyStimulus(0, BASE + 32'd3, 0, 0, 1, 0);
    checkOutput("cycles restart", dataOut, 32'h2);

    applyStimulus(0, 32'd4095, 32'hCAFE_0001, 1, 0, 0);
    applyStimulus(0, 32'd0, 32'h11, 1, 0, 0);
    applyStimulus(0, 32'd4096, 32'h77, 1, 0, 0);
    applyStimulus(0, 32'd4096, 0, 0, 1, 0);
    checkOutput("unmapped 4096", dataOut, 32'h0);
    applyStimulus(0, 32'd0, 0, 0, 1, 0);
    checkOutput("ram0 no alias", dataOut, 32'h11);
    applyStimulus(0, 32'd4095, 0, 0, 1, 0);
    checkOutput("ram top word", dataOut, 32'hCAFE_0001);
    applyStimulus(0, BASE + 32'd4, 32'h55, 1, 0, 0);
    applyStimulus(0, BASE + 32'd4, 0, 0, 1, 0);
    checkOutput("unmapped mmio", dataOut, 32'h0);
    applyStimulus(0, BASE + 32'd1, 32'hFF, 1, 0, 0);
    applyStimulus(0, BASE, 0, 0, 1, 0);
    checkOutput("led after ro write", dataOut, 32'hA5);

    applyStimulus(1, 32'd5, 32'h0, 1, 1, 0);
    checkOutput("midreset LEDs_o", {24'h0, leds}, 32'h0);
    checkOutput("midreset data_o", dataOut, 32'h0);
    applyStimulus(0, BASE + 32'd3, 0, 0, 1, 0);
    checkOutput("cycles after reset", dataOut, 32'h0);
    applyStimulus(0, 32'd5, 0, 0, 1, 0);
    checkOutput("ram retained", dataOut, 32'hDEAD_BEEF);
    applyStimulus(0, BASE + 32'd3, 0, 0, 1, 0);
    checkOutput("cycles counting", dataOut, 32'h2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
